// File: rtl/inlet_dose_scheduler_pkg.sv
// Shared definitions for the microfluidic valve controllers.
// - valve_state_e : sequencer states (IDLE, GAP, DOSE, FLUSH)
// - DEF_*_CYCLES  : default break-before-make gap and flush lengths
// - cnt_width()   : width of the single down-counter that times every state
package mfda_valve_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GAP   = 2'd1,
        DOSE  = 2'd2,
        FLUSH = 2'd3
    } valve_state_e;

    localparam int DEF_GAP_CYCLES   = 4;
    localparam int DEF_FLUSH_CYCLES = 32;

    // The counter must hold the largest reload value of any state, so take
    // the widest of the dose field and the bits needed for the fixed intervals.
    function automatic int cnt_width(input int dose_w, input int flush_cycles,
                                     input int gap_cycles);
        int w;
        w = dose_w;
        if ($clog2(flush_cycles + 1) > w) begin
            w = $clog2(flush_cycles + 1);
        end
        if ($clog2(gap_cycles + 1) > w) begin
            w = $clog2(gap_cycles + 1);
        end
        return w;
    endfunction

endpackage

// File: rtl/inlet_dose_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter.
// - req     : request vector, one bit per requester
// - ptr     : index of the requester that has highest priority this round
// - winner  : one-hot grant (all zero when no request)
// - win_idx : binary index of the winner
// - any_req : at least one request is present
// The pointer register lives in the parent so it only moves on a real grant.
module rr_arbiter #(
    parameter int N     = 3,
    parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N-1:0]     winner,
    output logic [IDX_W-1:0] win_idx,
    output logic             any_req
);

    logic             found_s;
    int               pos_s;
    logic [IDX_W-1:0] idx_s;

    // Scan the requesters starting at ptr and wrapping once; first hit wins.
    always_comb begin
        winner  = '0;
        win_idx = '0;
        found_s = 1'b0;
        pos_s   = 0;
        idx_s   = '0;
        for (int k = 0; k < N; k++) begin
            pos_s = int'(ptr) + k;
            if (pos_s >= N) begin
                pos_s = pos_s - N;
            end else begin
                pos_s = pos_s;
            end
            idx_s = IDX_W'(pos_s);
            if (!found_s && req[idx_s]) begin
                found_s        = 1'b1;
                winner[idx_s]  = 1'b1;
                win_idx        = idx_s;
            end else begin
                found_s = found_s;
            end
        end
        any_req = |req;
    end

endmodule

// File: rtl/inlet_dose_scheduler.sv
// Time-shares the single mixer/outlet channel among N_INLET solution inlets.
// Each round-robin grant runs: all-closed gap -> timed dose -> flush.
// Ports:
// - clk, rst_n           : clock, asynchronous active-low reset
// - req[N]               : level request per inlet, held until gnt
// - dose_len[N*DOSE_W]   : per-inlet dose length in cycles, sampled at grant
// - abort                : cut the current sequence short (GAP or DOSE only)
// - gnt[N], done[N]      : one-cycle one-hot pulses (accepted / finished)
// - aborted              : qualifies done when the sequence was aborted
// - valve_inlet[N], valve_flush, valve_out : registered valve drives
// - busy                 : sequencer not idle
module inlet_dose_scheduler
    import mfda_valve_pkg::*;
#(
    parameter int N_INLET      = 3,
    parameter int DOSE_W       = 16,
    parameter int GAP_CYCLES   = DEF_GAP_CYCLES,
    parameter int FLUSH_CYCLES = DEF_FLUSH_CYCLES
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [N_INLET-1:0]         req,
    input  logic [N_INLET*DOSE_W-1:0]  dose_len,
    input  logic                       abort,
    output logic [N_INLET-1:0]         gnt,
    output logic [N_INLET-1:0]         done,
    output logic                       aborted,
    output logic [N_INLET-1:0]         valve_inlet,
    output logic                       valve_flush,
    output logic                       valve_out,
    output logic                       busy
);

    localparam int CNT_W = cnt_width(DOSE_W, FLUSH_CYCLES, GAP_CYCLES);
    localparam int IDX_W = $clog2(N_INLET);

    valve_state_e        state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [IDX_W-1:0]    cur_idx_q, cur_idx_d;
    logic [IDX_W-1:0]    ptr_q, ptr_d;
    logic [DOSE_W-1:0]   dose_q, dose_d;
    logic                abort_flag_q, abort_flag_d;
    logic [N_INLET-1:0]  gnt_q, gnt_d;
    logic [N_INLET-1:0]  done_q, done_d;
    logic                aborted_q, aborted_d;
    logic [N_INLET-1:0]  valve_inlet_q, valve_inlet_d;
    logic                valve_flush_q, valve_flush_d;
    logic                valve_out_q, valve_out_d;
    logic                busy_q, busy_d;

    logic [N_INLET-1:0]  winner_s;
    logic [IDX_W-1:0]    win_idx_s;
    logic                any_req_s;
    logic [DOSE_W-1:0]   sel_dose_s;

    function automatic logic [N_INLET-1:0] idx_onehot(input logic [IDX_W-1:0] idx);
        logic [N_INLET-1:0] oh;
        oh      = '0;
        oh[idx] = 1'b1;
        return oh;
    endfunction

    rr_arbiter #(
        .N     (N_INLET),
        .IDX_W (IDX_W)
    ) u_arb (
        .req     (req),
        .ptr     (ptr_q),
        .winner  (winner_s),
        .win_idx (win_idx_s),
        .any_req (any_req_s)
    );

    // Pick the winner's dose length out of the packed bus with constant slices.
    always_comb begin
        sel_dose_s = '0;
        for (int i = 0; i < N_INLET; i++) begin
            if (win_idx_s == IDX_W'(i)) begin
                sel_dose_s = dose_len[i*DOSE_W +: DOSE_W];
            end else begin
                sel_dose_s = sel_dose_s;
            end
        end
    end

    // Sequencer next-state, counter and pulse generation; valve drives are
    // decoded from the next state so the registered pins track the state flop.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        cur_idx_d    = cur_idx_q;
        ptr_d        = ptr_q;
        dose_d       = dose_q;
        abort_flag_d = abort_flag_q;
        gnt_d        = '0;
        done_d       = '0;
        aborted_d    = 1'b0;

        case (state_q)
            IDLE: begin
                if (any_req_s) begin
                    state_d      = GAP;
                    cur_idx_d    = win_idx_s;
                    dose_d       = sel_dose_s;
                    cnt_d        = CNT_W'(GAP_CYCLES - 1);
                    gnt_d        = winner_s;
                    abort_flag_d = 1'b0;
                    if (win_idx_s == IDX_W'(N_INLET - 1)) begin
                        ptr_d = '0;
                    end else begin
                        ptr_d = win_idx_s + IDX_W'(1);
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            GAP: begin
                if (abort) begin
                    state_d   = IDLE;
                    done_d    = idx_onehot(cur_idx_q);
                    aborted_d = 1'b1;
                end else if (cnt_q == CNT_W'(0)) begin
                    if (dose_q == DOSE_W'(0)) begin
                        // Empty dose: nothing reached the channel, so no flush.
                        state_d = IDLE;
                        done_d  = idx_onehot(cur_idx_q);
                    end else begin
                        state_d = DOSE;
                        cnt_d   = CNT_W'(dose_q) - CNT_W'(1);
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            DOSE: begin
                // An abort on the final dose cycle still counts as an abort.
                if (abort || (cnt_q == CNT_W'(0))) begin
                    state_d      = FLUSH;
                    cnt_d        = CNT_W'(FLUSH_CYCLES - 1);
                    abort_flag_d = abort;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            FLUSH: begin
                if (cnt_q == CNT_W'(0)) begin
                    state_d   = IDLE;
                    done_d    = idx_onehot(cur_idx_q);
                    aborted_d = abort_flag_q;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (state_d == DOSE) begin
            valve_inlet_d = idx_onehot(cur_idx_d);
        end else begin
            valve_inlet_d = '0;
        end
        valve_flush_d = (state_d == FLUSH);
        valve_out_d   = (state_d == DOSE) || (state_d == FLUSH);
        busy_d        = (state_d != IDLE);
    end

    // State, counter and output registers; reset closes every valve at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            cur_idx_q     <= '0;
            ptr_q         <= '0;
            dose_q        <= '0;
            abort_flag_q  <= 1'b0;
            gnt_q         <= '0;
            done_q        <= '0;
            aborted_q     <= 1'b0;
            valve_inlet_q <= '0;
            valve_flush_q <= 1'b0;
            valve_out_q   <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            cur_idx_q     <= cur_idx_d;
            ptr_q         <= ptr_d;
            dose_q        <= dose_d;
            abort_flag_q  <= abort_flag_d;
            gnt_q         <= gnt_d;
            done_q        <= done_d;
            aborted_q     <= aborted_d;
            valve_inlet_q <= valve_inlet_d;
            valve_flush_q <= valve_flush_d;
            valve_out_q   <= valve_out_d;
            busy_q        <= busy_d;
        end
    end

    assign gnt         = gnt_q;
    assign done        = done_q;
    assign aborted     = aborted_q;
    assign valve_inlet = valve_inlet_q;
    assign valve_flush = valve_flush_q;
    assign valve_out   = valve_out_q;
    assign busy        = busy_q;

endmodule
